// File: rtl/udma_spi_slave_if.sv
// SPI mode-0 target endpoint: oversamples SCK/CSN/MOSI, deserialises RX bytes onto a
// valid/ready stream and serialises a one-byte-buffered TX stream onto MISO.
module udma_spi_slave_if #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_DATA   = 8'hFF
) (
  input  logic       sys_clk_i,
  input  logic       rst_i,
  input  logic       spi_clk_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic       underrun_o,
  output logic       frame_err_o
);

  localparam int DATA_W = 8;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
  logic                   sck_prev, csn_prev;
  logic                   sck_s, csn_s, mosi_s;
  logic                   sck_rise, sck_fall, csn_assert, csn_deassert;

  logic [2:0]        bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] buf_data;
  logic              buf_full;

  logic              frame_start, frame_end, rise_act, fall_act;
  logic              byte_done, load_tx, rx_accept, frame_err, buf_wr;
  logic [DATA_W-1:0] load_byte;

  // CSN synchroniser resets to "asserted" so a CSN already low at reset release
  // produces no assert strobe; the resulting deassert strobe is ignored in IDLE.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync <= '0;
      csn_sync <= '0;
      sck_prev <= 1'b0;
      csn_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_clk_i};
      csn_sync <= {csn_sync[SYNC_STAGES-2:0], spi_csn_i};
      sck_prev <= sck_s;
      csn_prev <= csn_s;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
  end

  assign sck_s        = sck_sync[SYNC_STAGES-1];
  assign csn_s        = csn_sync[SYNC_STAGES-1];
  assign mosi_s       = mosi_sync[SYNC_STAGES-1];
  assign sck_rise     = sck_s & ~sck_prev;
  assign sck_fall     = ~sck_s & sck_prev;
  assign csn_assert   = ~csn_s & csn_prev;
  assign csn_deassert = csn_s & ~csn_prev;

  // ---- frame control ----
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    rise_act    = 1'b0;
    fall_act    = 1'b0;
    case (state)
      IDLE: begin
        if (csn_assert) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        rise_act = sck_rise;
        fall_act = sck_fall;
        if (csn_deassert) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A rise coinciding with deassert completes its byte before the frame closes.
  assign byte_done = rise_act && (bit_cnt == 3'd7);
  assign frame_err = frame_end && (rise_act ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0));
  assign load_tx   = frame_start || byte_done;
  assign load_byte = buf_full ? buf_data : IDLE_DATA;
  assign rx_accept = byte_done && (!rx_valid_o || rx_ready_i);
  assign buf_wr    = tx_valid_i && !buf_full;

  assign tx_ready_o    = ~buf_full;
  assign busy_o        = (state == ACTIVE);
  assign spi_miso_oe_o = busy_o;

  // ---- registered control and status ----
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt     <= 3'd0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      buf_full    <= 1'b0;
      spi_miso_o  <= 1'b0;
      overflow_o  <= 1'b0;
      underrun_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      overflow_o  <= byte_done && !rx_accept;
      underrun_o  <= load_tx && !buf_full;
      frame_err_o <= frame_err;

      if (frame_start || frame_end) bit_cnt <= 3'd0;
      else if (rise_act)            bit_cnt <= bit_cnt + 3'd1;

      if (rx_accept) begin
        rx_data_o  <= {rx_shift, mosi_s};
        rx_valid_o <= 1'b1;
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      // A write in the same cycle as a load refills the buffer with the new byte.
      if (buf_wr)       buf_full <= 1'b1;
      else if (load_tx) buf_full <= 1'b0;

      if (frame_start)    spi_miso_o <= load_byte[DATA_W-1];
      else if (frame_end) spi_miso_o <= 1'b0;
      else if (fall_act)  spi_miso_o <= tx_shift[DATA_W-1];
    end
  end

  // ---- shift datapath ----
  // At frame start the MSB goes straight to MISO; at a byte boundary the full byte
  // is kept so the following SCK fall presents its MSB.
  always_ff @(posedge sys_clk_i) begin
    if (rise_act) rx_shift <= {rx_shift[DATA_W-3:0], mosi_s};

    if (buf_wr) buf_data <= tx_data_i;

    if (frame_start)    tx_shift <= {load_byte[DATA_W-2:0], 1'b0};
    else if (byte_done) tx_shift <= load_byte;
    else if (fall_act)  tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
  end

endmodule
